// File: rtl/pt_loader.sv
// Page-table loader: copies ENTRIES consecutive memory words into the
// special-register page table at SR_BASE.., one read then one SR write each.
// Optional feature macro: PT_LOADER_CHKSUM_EN (running XOR of loaded words).
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start, i_base_addr           load request and memory address of entry 0
//   o_busy, o_done, o_err          status: in progress, done pulse, sticky abort
//   o_mem_req/addr, i_mem_ack/data/err   memory read handshake
//   o_sr_addr/data/we              special-register write port
//   o_pag_block                    paging inhibit (mirrors o_busy)
//   o_checksum                     XOR of loaded entries (0 when feature off)
module pt_loader #(
  parameter int unsigned ENTRIES = 16,
  parameter logic [15:0] SR_BASE = 16'h200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_base_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_mem_req,
  output logic [23:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data,
  input  logic        i_mem_err,
  output logic [15:0] o_sr_addr,
  output logic [15:0] o_sr_data,
  output logic        o_sr_we,
  output logic        o_pag_block,
  output logic [15:0] o_checksum
);

  localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                err_d;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    word_d  = word_q;
    err_d   = o_err;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (i_mem_ack) begin
          if (i_mem_err) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            word_d  = i_mem_data;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      word_q     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_sr_we    <= 1'b0;
      o_sr_addr  <= '0;
      o_sr_data  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      word_q     <= word_d;
      o_busy     <= (state_d != IDLE);
      o_done     <= (state_d == DONE);
      o_err      <= err_d;
      o_mem_req  <= (state_d == FETCH);
      o_mem_addr <= base_d + ADDR_W'(idx_d);
      o_sr_we    <= (state_d == WRITE);
      o_sr_addr  <= SR_BASE + DATA_W'(idx_d);
      o_sr_data  <= word_d;
    end
  end

  assign o_pag_block = o_busy;

`ifdef PT_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] chk_d;

  // Running XOR: cleared on an accepted start, folded on each good read
  always_comb begin
    chk_d = o_checksum;
    if (state_q == IDLE && i_start) begin
      chk_d = '0;
    end else if (state_q == FETCH && i_mem_ack && !i_mem_err) begin
      chk_d = o_checksum ^ i_mem_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_checksum <= '0;
    end else begin
      o_checksum <= chk_d;
    end
  end
`else
  assign o_checksum = '0;
`endif

endmodule

// File: doc/pt_loader.md
PT_LOADER -- requirements
Module: pt_loader

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of page-table entries loaded per run (index width 4).
REQ-002 SHALL have parameter SR_BASE, default 16'h200, meaning special-register address of page-table entry 0.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  load request; sampled only in IDLE.
REQ-006 SHALL have port i_base_addr  input  24  word address of entry 0 in memory.
REQ-007 SHALL have port o_busy  output  1  high while a load is in progress.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse on successful completion.
REQ-009 SHALL have port o_err  output  1  sticky abort flag.
REQ-010 SHALL have port o_mem_req  output  1  memory read request.
REQ-011 SHALL have port o_mem_addr  output  24  memory read word address.
REQ-012 SHALL have port i_mem_ack  input  1  read completion; data valid in the same cycle.
REQ-013 SHALL have port i_mem_data  input  16  read data.
REQ-014 SHALL have port i_mem_err  input  1  bus error; meaningful only together with i_mem_ack.
REQ-015 SHALL have port o_sr_addr  output  16  special-register write address.
REQ-016 SHALL have port o_sr_data  output  16  special-register write data.
REQ-017 SHALL have port o_sr_we  output  1  special-register write strobe.
REQ-018 SHALL have port o_pag_block  output  1  equals o_busy; core forces paging off while high.
REQ-019 SHALL have port o_checksum  output  16  XOR of loaded entries (see Configuration).

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, WRITE, DONE, with entry index idx (4 bits).
REQ-021 IDLE: on i_start=1, SHALL latch i_base_addr, clear idx and o_err, and go to FETCH the next cycle.
REQ-022 FETCH: SHALL hold o_mem_req=1 and o_mem_addr=base+idx (24-bit, wrapping modulo 2^24) stable until i_mem_ack=1.
REQ-023 FETCH with i_mem_ack=1 and i_mem_err=0: SHALL latch i_mem_data and go to WRITE.
REQ-024 FETCH with i_mem_ack=1 and i_mem_err=1: SHALL set o_err, perform no SR write, return to IDLE, and leave o_done low.
REQ-025 WRITE: SHALL assert o_sr_we for exactly one cycle with o_sr_addr=SR_BASE+idx and o_sr_data=latched word (all 16 bits, unmasked).
REQ-026 WRITE: if idx=ENTRIES-1, SHALL go to DONE; otherwise SHALL increment idx and return to FETCH.
REQ-027 DONE: SHALL assert o_done for one cycle and then go to IDLE.
REQ-028 o_busy SHALL be high in FETCH, WRITE and DONE, and low in IDLE.
REQ-029 i_start SHALL be ignored outside IDLE.
REQ-030 i_mem_ack outside FETCH SHALL be ignored.
REQ-031 Zero-wait memory: start accepted in cycle 0 SHALL give the first o_sr_we in cycle 2, the last in cycle 32, and o_done in cycle 33.
REQ-032 o_sr_addr, o_sr_data and o_mem_addr SHALL be don't-care when their strobes are low; o_sr_we SHALL never be high outside WRITE.

Reset
REQ-033 i_rst_n=0 SHALL immediately force IDLE, idx=0, o_busy=0, o_done=0, o_err=0, o_mem_req=0, o_sr_we=0, o_checksum=0, regardless of the clock.
REQ-034 Reset mid-load SHALL abort with no further SR writes; entries already written are not undone.

Configuration
REQ-035 Macro PT_LOADER_CHKSUM_EN defined: o_checksum SHALL clear at start and XOR in each latched word, so it holds the XOR of all ENTRIES words when o_done pulses; it SHALL be held until the next start.
REQ-036 Macro PT_LOADER_CHKSUM_EN undefined: o_checksum SHALL be constant 0 and no checksum register SHALL exist.

Verification
REQ-037 Base 24'h001000, memory word k = 16'h0100+k, zero-wait ack -> 16 SR writes at 16'h200..16'h20F with data 16'h0100..16'h010F; o_done in cycle 33; checksum 16'h0000 (with macro).
REQ-038 Ack delayed by 3 cycles per read -> o_mem_addr and o_mem_req held stable while waiting; same write sequence; o_done in cycle 81.
REQ-039 i_mem_err with ack on entry 5 -> exactly 5 SR writes (16'h200..16'h204); o_err=1, o_done never asserted; next i_start clears o_err.
REQ-040 i_start pulsed in cycle 10 of a load -> ignored; write sequence unchanged.
REQ-041 i_rst_n low in cycle 7 -> all outputs 0 asynchronously; no o_sr_we after reset; a new start after release gives a full load.
REQ-042 Base 24'hFFFFF8 -> o_mem_addr wraps from 24'hFFFFFF to 24'h000000 at idx 8.
